pool_ctrl: RTL and testbench
============================

# pool_ctrl

Sequencer for the max-pooling stage of the renkon accelerator. On a start request it scans one feature map out of the feature memory in raster order and drives the pool datapath's line-buffer enable and output enable. It then generates write enables and addresses for each pooled result, and reports completion to the layer controller. One instance serves one pool datapath; the stride always equals the pool window size.

## Interface
- DWIDTH, 16, data width of pooled pixel forwarded to output memory
- LWIDTH, 10, width of size registers (feature/pool size)
- MEMSIZE, 12, address width of feature and output memories
- clk  in  1  clock, all logic on rising edge
- xrst  in  1  synchronous active-low reset
- req  in  1  start request, sampled only while ack=1
- in_offset  in  MEMSIZE  base address of input feature map
- out_offset  in  MEMSIZE  base address of pooled output map
- w_fea_size  in  LWIDTH  feature map side N, latched on accepted req
- w_pool_size  in  LWIDTH  pool window side P, latched on accepted req
- pixel_out  in  DWIDTH  pooled result from pool datapath
- ack  out  1  high when idle/done; low while a map is in progress
- mem_feat_addr  out  MEMSIZE  feature memory read address (1-cycle read latency)
- buf_feat_en  out  1  to pool buf_feat_en; marks a valid pixel entering the line buffer
- pool_out_en  out  1  to pool out_en; window complete at a stride-aligned position
- out_we  out  1  output memory write enable
- out_addr  out  MEMSIZE  output memory write address
- out_data  out  DWIDTH  registered copy of pixel_out, valid with out_we

## Operation
- States: S_IDLE, S_SCAN, S_DRAIN.
- S_IDLE: ack=1. On req=1, latch N, P and both offsets, then go to S_SCAN.
  - If P==0 or P>N, the configuration is illegal: go to S_DRAIN with no reads and no outputs.
- S_SCAN: issues read k (k=0..N²-1) with mem_feat_addr = in_offset + k, one per cycle, no stalls. Row r = k / N and column c = k mod N are kept as separate counters; no division.
  - After issuing k = N²-1, go to S_DRAIN.
- S_DRAIN: counts 3 cycles for the enable pipeline to empty, then goes to S_IDLE.
  - For an illegal configuration, the drain is 0 cycles (direct return to S_IDLE).
- Pixel k qualifies when (r mod P == P-1) and (c mod P == P-1). Modulo tracking uses per-axis window counters that wrap at P-1.
  - The column window counter resets at each row start.
  - Rows/columns beyond floor(N/P)·P are scanned but never qualify.
- Output index j starts at 0 per map and increments per out_we. out_addr = out_offset + j.
- req while ack=0 is ignored (not queued).
- xrst=0 at any time forces S_IDLE, clears all counters and pipeline enables, and drops any in-flight output.
- Address arithmetic is modulo 2^MEMSIZE (wraps silently).

## Timing
- Reset values: ack=1, buf_feat_en=0, pool_out_en=0, out_we=0, mem_feat_addr=0, out_addr=0, out_data=0.
- Cycle 0: req sampled high with ack=1. Cycle 1: ack=0, first address presented.
- Read k is presented at cycle 1+k, and buf_feat_en is high at cycle 2+k (aligned with memory data).
- For qualifying k:
  - pool_out_en is high at cycle 3+k.
  - out_we is high at cycle 4+k, with out_data = pixel_out sampled at the end of cycle 3+k.
- ack returns high at cycle N²+4 (legal config) or cycle 2 (illegal). A new req is accepted on the same cycle ack is high.
- buf_feat_en is continuous for N² cycles; pool_out_en and out_we are single-cycle pulses.

## Test plan
- N=4, P=2: buf_feat_en high cycles 2–17; pool_out_en at cycles 8,10,16,18; out_we at 9,11,17,19 with out_addr=out_offset+0..3; ack high at cycle 20.
- N=5, P=2: qualifying k=6,8,16,18 → out_we at 10,12,20,22, 4 writes only; ack high at cycle 29.
- N=3, P=1: out_we high every cycle 4–12, out_addr=out_offset+0..8, out_data tracks pixel_out delayed by 1.
- P=0 (and separately P=6 with N=4): no buf_feat_en/out_we; ack low only at cycle 1, high at cycle 2.
- req pulsed during S_SCAN of an N=4 map: no effect on counts or timing. req held high across completion: second map starts at cycle 20, with reads from in_offset again.
- xrst=0 at cycle 7 of an N=4 map: next cycle all outputs at reset values, ack=1, no further out_we. A fresh req completes normally.

Source files
------------

// File: rtl/pool_ctrl.sv
// pool_ctrl: raster-scan sequencer for the max-pooling datapath.
// Issues feature reads, window-complete strobes and output writes.
module pool_ctrl #(
  parameter int DWIDTH  = 16,
  parameter int LWIDTH  = 10,
  parameter int MEMSIZE = 12
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [MEMSIZE-1:0] in_offset,
  input  logic [MEMSIZE-1:0] out_offset,
  input  logic [LWIDTH-1:0]  w_fea_size,
  input  logic [LWIDTH-1:0]  w_pool_size,
  input  logic [DWIDTH-1:0]  pixel_out,
  output logic               ack,
  output logic [MEMSIZE-1:0] mem_feat_addr,
  output logic               buf_feat_en,
  output logic               pool_out_en,
  output logic               out_we,
  output logic [MEMSIZE-1:0] out_addr,
  output logic [DWIDTH-1:0]  out_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t             state;
  logic [LWIDTH-1:0]  n;
  logic [LWIDTH-1:0]  p;
  logic [LWIDTH-1:0]  row;
  logic [LWIDTH-1:0]  col;
  logic [LWIDTH-1:0]  wrow;
  logic [LWIDTH-1:0]  wcol;
  logic [MEMSIZE-1:0] out_ptr;
  logic [1:0]         drain;
  logic               qual;

  logic row_end;
  logic last_px;
  logic hit;
  logic legal;
  logic wrow_end;
  logic wcol_end;

  always_comb begin
    row_end  = (col == n - 1'b1);
    last_px  = row_end && (row == n - 1'b1);
    wrow_end = (wrow == p - 1'b1);
    wcol_end = (wcol == p - 1'b1);
    hit      = wrow_end && wcol_end;
    legal    = (w_pool_size != '0) &&
               (w_pool_size <= w_fea_size);
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state         <= S_IDLE;
      n             <= '0;
      p             <= '0;
      row           <= '0;
      col           <= '0;
      wrow          <= '0;
      wcol          <= '0;
      out_ptr       <= '0;
      drain         <= '0;
      qual          <= 1'b0;
      ack           <= 1'b1;
      mem_feat_addr <= '0;
      buf_feat_en   <= 1'b0;
      pool_out_en   <= 1'b0;
      out_we        <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
    end else begin
      // enable pipeline: read -> data valid -> window -> write
      buf_feat_en <= (state == S_SCAN);
      qual        <= (state == S_SCAN) && hit;
      pool_out_en <= qual;
      out_we      <= pool_out_en;
      out_data    <= pixel_out;
      if (pool_out_en) begin
        out_addr <= out_ptr;
        out_ptr  <= out_ptr + 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (req) begin
            n             <= w_fea_size;
            p             <= w_pool_size;
            out_ptr       <= out_offset;
            mem_feat_addr <= in_offset;
            row           <= '0;
            col           <= '0;
            wrow          <= '0;
            wcol          <= '0;
            ack           <= 1'b0;
            drain         <= '0;
            state         <= legal ? S_SCAN : S_DRAIN;
          end
        end
        S_SCAN: begin
          if (last_px) begin
            state <= S_DRAIN;
            drain <= 2'd2;
          end else begin
            mem_feat_addr <= mem_feat_addr + 1'b1;
            if (row_end) begin
              col  <= '0;
              wcol <= '0;
              row  <= row + 1'b1;
              wrow <= wrow_end ? '0 : wrow + 1'b1;
            end else begin
              col  <= col + 1'b1;
              wcol <= wcol_end ? '0 : wcol + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain == '0) begin
            state <= S_IDLE;
            ack   <= 1'b1;
          end else begin
            drain <= drain - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: randomized bench for pool_ctrl against a
// per-cycle expectation table built from the scan rules.
module tb_pool_ctrl;

  logic        clk = 1'b0;
  logic        xrst;
  logic        req;
  logic [11:0] in_offset;
  logic [11:0] out_offset;
  logic [9:0]  w_fea_size;
  logic [9:0]  w_pool_size;
  logic [15:0] pixel_out;
  logic        ack;
  logic [11:0] mem_feat_addr;
  logic        buf_feat_en;
  logic        pool_out_en;
  logic        out_we;
  logic [11:0] out_addr;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  pool_ctrl dut (
    .clk          (clk),
    .xrst         (xrst),
    .req          (req),
    .in_offset    (in_offset),
    .out_offset   (out_offset),
    .w_fea_size   (w_fea_size),
    .w_pool_size  (w_pool_size),
    .pixel_out    (pixel_out),
    .ack          (ack),
    .mem_feat_addr(mem_feat_addr),
    .buf_feat_en  (buf_feat_en),
    .pool_out_en  (pool_out_en),
    .out_we       (out_we),
    .out_addr     (out_addr),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ack", 32'(ack), 32'd1);
    check("rst_bfe", 32'(buf_feat_en), 32'd0);
    check("rst_poe", 32'(pool_out_en), 32'd0);
    check("rst_we", 32'(out_we), 32'd0);
    check("rst_maddr", 32'(mem_feat_addr), 32'd0);
    check("rst_oaddr", 32'(out_addr), 32'd0);
    check("rst_odata", 32'(out_data), 32'd0);
  endtask

  task automatic scramble();
    in_offset   = 12'($urandom);
    out_offset  = 12'($urandom);
    w_fea_size  = 10'($urandom);
    w_pool_size = 10'($urandom);
  endtask

  // mode 0: req single pulse, 1: random req during map, 2: req held
  task automatic run_map(input int n, input int p,
                         input logic [11:0] ioff,
                         input logic [11:0] ooff,
                         input int mode, input int abort_at);
    bit          ebfe[128];
    bit          epoe[128];
    bit          ewe[128];
    logic [11:0] ewa[128];
    logic [15:0] pix[128];
    bit          legal;
    int          last;
    int          j;
    legal = (p > 0) && (p <= n);
    last  = legal ? n * n + 4 : 2;
    for (int t = 0; t < 128; t++) begin
      ebfe[t] = 0; epoe[t] = 0; ewe[t] = 0; ewa[t] = '0;
    end
    j = 0;
    if (legal) begin
      for (int k = 0; k < n * n; k++) begin
        ebfe[2 + k] = 1;
        if (((k / n) % p == p - 1) && ((k % n) % p == p - 1)) begin
          epoe[3 + k] = 1;
          ewe[4 + k]  = 1;
          ewa[4 + k]  = 12'(ooff + j);
          j++;
        end
      end
    end
    check("ack_start", 32'(ack), 32'd1);
    req         = 1'b1;
    in_offset   = ioff;
    out_offset  = ooff;
    w_fea_size  = 10'(n);
    w_pool_size = 10'(p);
    pixel_out   = 16'($urandom);
    pix[0]      = pixel_out;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      check("ack", 32'(ack), 32'(t == last));
      check("bfe", 32'(buf_feat_en), 32'(ebfe[t]));
      check("poe", 32'(pool_out_en), 32'(epoe[t]));
      check("we", 32'(out_we), 32'(ewe[t]));
      if (ewe[t]) begin
        check("oaddr", 32'(out_addr), 32'(ewa[t]));
        check("odata", 32'(out_data), 32'(pix[t-1]));
      end
      if (legal && t <= n * n)
        check("maddr", 32'(mem_feat_addr), 32'(12'(ioff + t - 1)));
      if (t == abort_at) begin
        xrst = 1'b0;
        req  = 1'b0;
        @(negedge clk);
        check_reset_vals();
        xrst = 1'b1;
        return;
      end
      if (t == last)
        req = (mode == 2);
      else if (mode == 1)
        req = 1'($urandom);
      if (t != last || mode != 2)
        scramble();
      pixel_out = 16'($urandom);
      pix[t]    = pixel_out;
    end
  endtask

  task automatic idle(input int cycles);
    req = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_ack", 32'(ack), 32'd1);
      check("idle_bfe", 32'(buf_feat_en), 32'd0);
      check("idle_we", 32'(out_we), 32'd0);
      pixel_out = 16'($urandom);
    end
  endtask

  initial begin
    int n;
    int p;
    xrst        = 1'b0;
    req         = 1'b0;
    in_offset   = '0;
    out_offset  = '0;
    w_fea_size  = '0;
    w_pool_size = '0;
    pixel_out   = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    xrst = 1'b1;

    run_map(4, 2, 12'h010, 12'h200, 0, 0);
    idle(2);
    run_map(5, 2, 12'h123, 12'h300, 0, 0);
    idle(1);
    run_map(3, 1, 12'h040, 12'h400, 0, 0);
    idle(1);
    run_map(4, 0, 12'h050, 12'h500, 0, 0);
    idle(1);
    run_map(4, 6, 12'h060, 12'h600, 0, 0);
    idle(1);
    run_map(4, 2, 12'h070, 12'h700, 1, 0);
    idle(1);
    run_map(4, 2, 12'h080, 12'h800, 2, 0);
    run_map(4, 2, 12'h080, 12'h810, 0, 0);
    idle(1);
    run_map(4, 2, 12'h090, 12'h900, 0, 7);
    idle(6);
    run_map(4, 2, 12'h0A0, 12'hA00, 0, 0);
    idle(1);
    run_map(3, 2, 12'hFFE, 12'hFFF, 0, 0);
    run_map(6, 3, 12'hFF0, 12'hFFE, 0, 0);
    idle(1);
    for (int i = 0; i < 12; i++) begin
      n = int'($urandom_range(1, 7));
      p = int'($urandom_range(0, n + 1));
      run_map(n, p, 12'($urandom), 12'($urandom),
              int'($urandom_range(0, 1)), 0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
